mc_controller: RTL and testbench

Main control unit for the multicycle MIPS datapath. It is a Moore state machine that sequences fetch, decode, execute, memory and writeback across several cycles, so that one ALU and one unified instruction/data memory are shared within each instruction. It sits beside the datapath inside `top`. It takes `op`/`funct` from the instruction register and `zero` from the ALU, and drives every mux select and write enable.

---
 rtl/mc_defs.sv | 50 +++++
 rtl/mc_aludec.sv | 35 +++
 rtl/mc_controller.sv | 132 +++++++++++++
 tb/tb_mc_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mc_defs.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operation classes and ALU control values.
package mc_defs;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2a;

  typedef enum logic [1:0] {
    AluopAdd   = 2'b00,
    AluopSub   = 2'b01,
    AluopFunct = 2'b10
  } aluop_e;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
           (op == OpBeq) || (op == OpAddi) || (op == OpJ);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the ALU operation class and funct field to an ALU control
// code, flagging funct values the ALU does not implement.
module mc_aludec
  import mc_defs::*;
(
  input  aluop_e      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        badfunct
);

  always_comb begin
    alucontrol = AluAdd;
    badfunct   = 1'b0;
    unique case (aluop)
      AluopAdd: alucontrol = AluAdd;
      AluopSub: alucontrol = AluSub;
      AluopFunct: begin
        unique case (funct)
          FnAdd:   alucontrol = AluAdd;
          FnSub:   alucontrol = AluSub;
          FnAnd:   alucontrol = AluAnd;
          FnOr:    alucontrol = AluOr;
          FnSlt:   alucontrol = AluSlt;
          default: begin
            alucontrol = AluAdd;
            badfunct   = 1'b1;
          end
        endcase
      end
      default: alucontrol = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, driving every datapath select and write enable.
module mc_controller
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_e state_q;
  state_e st;
  aluop_e aluop;
  logic   pcwrite, branch, irwrite_raw, memwrite_raw, regwrite_raw, badfunct;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          case (op)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StExecute;
            OpBeq:      state_q <= StBranch;
            OpAddi:     state_q <= StAddiEx;
            OpJ:        state_q <= StJump;
            default:    state_q <= StFetch;
          endcase
        end
        StMemAdr:  state_q <= (op == OpLw) ? StMemRd : StMemWr;
        StMemRd:   state_q <= StMemWb;
        StExecute: state_q <= StAluWb;
        StAddiEx:  state_q <= StAddiWb;
        default:   state_q <= StFetch;
      endcase
    end
  end

  // While reset is held the outputs look like FETCH, so an aborted instruction
  // cannot leak a select change; write enables are masked separately below.
  assign st = rst ? StFetch : state_q;

  always_comb begin
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = AluopAdd;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    unique case (st)
      StFetch: begin
        alusrcb     = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      StMemWr: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = AluopFunct;
      end
      StAluWb: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      StBranch: begin
        alusrca = 1'b1;
        aluop   = AluopSub;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StAddiWb: regwrite_raw = 1'b1;
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .badfunct   (badfunct)
  );

  assign pcen     = ~rst & (pcwrite | (branch & zero));
  assign irwrite  = ~rst & irwrite_raw;
  assign memwrite = ~rst & memwrite_raw;
  assign regwrite = ~rst & regwrite_raw;
  assign illegal  = ((st == StDecode) & ~op_supported(op)) | ((st == StExecute) & badfunct);

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against a per-instruction
// phase model derived from the instruction timing and per-phase output table.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst, zero;
  logic [5:0] op, funct;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int errors = 0;
  int checks = 0;

  mc_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, pcsrc, alucontrol, illegal};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (pcen,iord,mw,irw,rd,m2r,rw,asa,asb,pcs,alu,ill)",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic pe, input logic io, input logic mw,
                                     input logic iw, input logic rd, input logic m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] alu,
                                     input logic ill);
    return {pe, io, mw, iw, rd, m2r, rw, asa, asb, pcs, alu, ill};
  endfunction

  function automatic bit known_op(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic int funct_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return -1;
    endcase
  endfunction

  localparam logic [15:0] ResetVec = {8'b0, 2'b01, 2'b00, 3'b010, 1'b0};

  function automatic logic [15:0] expect_phase(input string ph, input logic z,
                                               input logic [5:0] o, input logic [5:0] f);
    int fa = funct_alu(f);
    case (ph)
      "F":    return mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
      "D":    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, !known_op(o));
      "MA":   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
      "MR":   return mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
      "MWB":  return mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 0);
      "MW":   return mk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
      "EX":   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00,
                        (fa < 0) ? 3'b010 : 3'(fa), fa < 0);
      "AWB":  return mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
      "BR":   return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
      "AE":   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
      "AIWB": return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
      "J":    return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);
      default: return 16'hxxxx;
    endcase
  endfunction

  // Runs one instruction from its FETCH cycle; stop_after < 0 runs it to completion.
  // zmode 0/1 forces zero, 2 randomizes it every cycle.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int stop_after);
    string phases[$];
    phases = '{"F", "D"};
    case (o)
      6'b100011: phases = {phases, "MA", "MR", "MWB"};
      6'b101011: phases = {phases, "MA", "MW"};
      6'b000000: phases = {phases, "EX", "AWB"};
      6'b000100: phases = {phases, "BR"};
      6'b001000: phases = {phases, "AE", "AIWB"};
      6'b000010: phases = {phases, "J"};
      default: ;
    endcase
    op    = o;
    funct = f;
    foreach (phases[i]) begin
      if (stop_after >= 0 && i >= stop_after) return;
      zero = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
      #1;
      check_eq($sformatf("%s_c%0d_%s", name, i + 1, phases[i]), obs,
               expect_phase(phases[i], zero, o, f));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic hold_reset(input string name, input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      zero = 1'($urandom_range(1));
      #1;
      check_eq($sformatf("%s_r%0d", name, i), obs, ResetVec);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  localparam logic [5:0] OpTab[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                      6'b001000, 6'b000010, 6'b111111};
  localparam logic [5:0] FnTab[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};

  initial begin
    logic [5:0] o, f;
    rst   = 1'b1;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    hold_reset("rst_init", 2);

    run_instr("lw", 6'b100011, 6'h00, 2, -1);
    run_instr("sw", 6'b101011, 6'h00, 2, -1);
    run_instr("beq_z1", 6'b000100, 6'h00, 1, -1);
    run_instr("beq_z0", 6'b000100, 6'h00, 0, -1);
    run_instr("slt", 6'b000000, 6'h2a, 2, -1);
    run_instr("or", 6'b000000, 6'h25, 2, -1);
    run_instr("badop", 6'b111111, 6'h20, 2, -1);
    run_instr("badfn", 6'b000000, 6'h3f, 2, -1);
    run_instr("addi", 6'b001000, 6'h00, 2, -1);
    run_instr("j", 6'b000010, 6'h00, 2, -1);

    // Abort an R-type in EXECUTE with a 3-cycle reset, then resume from FETCH.
    run_instr("r_abort", 6'b000000, 6'h20, 2, 2);
    hold_reset("rst_mid", 3);
    run_instr("after_rst", 6'b000000, 6'h22, 2, -1);

    for (int n = 0; n < 200; n++) begin
      o = OpTab[$urandom_range(6)];
      if (o == 6'b111111 && $urandom_range(1) == 1) o = 6'($urandom);
      f = FnTab[$urandom_range(5)];
      if (f == 6'h00) f = 6'($urandom);
      if ($urandom_range(19) == 0) begin
        run_instr($sformatf("rnd%0d_cut", n), o, f, 2, 1 + $urandom_range(1));
        hold_reset($sformatf("rnd%0d", n), 1 + $urandom_range(2));
      end else begin
        run_instr($sformatf("rnd%0d", n), o, f, 2, -1);
      end
    end

    zero = 1'b0;
    #1;
    check_eq("final_fetch", obs, expect_phase("F", 1'b0, 6'd0, 6'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
